// File: rtl/pattern_scan_sched.sv
// rtl/pattern_scan_sched.sv - round-robin scheduler sharing one serial 10110 detector
//
// Grants one requester at a time, shifts its latched word MSB-first through
// a non-overlapping 10110 Mealy detector and reports the hit count tagged
// with the requester ID.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   ID_W   requester ID width, clog2(N_REQ)
//   W      word width in bits (>= 5)
//   CNT_W  hit counter width (saturating)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      per-requester request, held with data until own gnt
//   data     word of requester k at bits [k*W +: W]
//   gnt      one-hot, one-cycle pulse when a word is captured
//   busy     high while the scheduler is not idle
//   hit      one-cycle strobe per detected pattern
//   done     one-cycle pulse, done_id/hit_cnt valid
//   done_id  ID of the finished requester (held until next done/reset)
//   hit_cnt  detections in the finished word (held until next done/reset)

module pattern_scan_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               hit,
    output logic               done,
    output logic [ID_W-1:0]    done_id,
    output logic [CNT_W-1:0]   hit_cnt
);

    localparam int IDX_W = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_REPORT
    } state_t;

    typedef enum logic [2:0] {
        D_A,
        D_B,
        D_C,
        D_D,
        D_E
    } det_t;

    state_t           state;
    det_t             det;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  cur_id;
    logic [W-1:0]     word;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;

    // Round-robin pick: first set request at or above ptr, wrapping.
    logic             pick_valid;
    logic [ID_W-1:0]  pick_id;

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int cand;
            cand = (int'(ptr) + k) % N_REQ;
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(cand);
            end
        end
    end

    // Detector step for the bit currently addressed by idx.
    logic cur_bit;
    det_t det_nxt;
    logic det_hit;

    always_comb begin
        cur_bit = word[idx];
        det_nxt = D_A;
        det_hit = 1'b0;
        case (det)
            D_A: det_nxt = cur_bit ? D_B : D_A;
            D_B: det_nxt = cur_bit ? D_B : D_C;
            D_C: det_nxt = cur_bit ? D_D : D_A;
            D_D: det_nxt = cur_bit ? D_E : D_C;
            D_E: begin
                det_nxt = cur_bit ? D_B : D_A;
                det_hit = ~cur_bit;
            end
            default: det_nxt = D_A;
        endcase
    end

    // Saturating count including the bit being fed this cycle, so the
    // final bit's detection is reflected in the reported hit_cnt.
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (det_hit && (cnt != {CNT_W{1'b1}})) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    logic [ID_W-1:0] ptr_after;

    always_comb begin
        if (cur_id == ID_W'(N_REQ - 1)) begin
            ptr_after = '0;
        end else begin
            ptr_after = cur_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            det     <= D_A;
            ptr     <= '0;
            cur_id  <= '0;
            word    <= '0;
            idx     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            hit     <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            hit_cnt <= '0;
        end else begin
            gnt  <= '0;
            hit  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt    <= N_REQ'(1) << pick_id;
                        busy   <= 1'b1;
                        word   <= data[int'(pick_id)*W +: W];
                        cur_id <= pick_id;
                        cnt    <= '0;
                        det    <= D_A;
                        idx    <= IDX_W'(W - 1);
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    det <= det_nxt;
                    hit <= det_hit;
                    cnt <= cnt_nxt;
                    if (idx == '0) begin
                        done    <= 1'b1;
                        done_id <= cur_id;
                        hit_cnt <= cnt_nxt;
                        state   <= S_REPORT;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                S_REPORT: begin
                    ptr   <= ptr_after;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
